// File: rtl/multdiv_seq.sv
// Sequential signed 32-bit multiply (radix-2 Booth) and divide (restoring, on magnitudes)
// that borrows one external adder for every add, subtract and negate it needs.
module multdiv_seq (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy,
  output logic [31:0] add_x,
  output logic [31:0] add_y,
  output logic        add_cin,
  input  logic [31:0] add_sum,
  input  logic        add_cout,
  output logic [2:0]  o_dbg_state
);

  // Handshake: ctrl_MULT/ctrl_DIV are single-cycle start strobes that are accepted
  // unconditionally (aborting any operation in flight). data_resultRDY is a one-cycle
  // pulse with data_result/data_exception valid; there is no back-pressure.
  typedef enum logic [2:0] {
    S_IDLE, S_M_ITER, S_D_NEGA, S_D_NEGB, S_D_ITER, S_D_NEGQ, S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic [64:0] r_p;
  logic [31:0] r_a, r_b, r_q, r_r;
  logic [31:0] r_result;
  logic [4:0]  r_cnt;
  logic        r_sign, r_dz, r_mul, r_exc, r_rdy, r_clr;

  logic        w_start;
  logic [32:0] w_sum33;
  logic [31:0] w_rsh;
  logic        w_ovf;
  logic [31:0] w_add_x, w_add_y;
  logic        w_add_cin;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_sum33 = {w_add_x[31] ^ w_add_y[31] ^ add_cout, add_sum};
  assign w_rsh   = {r_r[30:0], r_q[31]};
  // Product fits in 32 signed bits only if bits 64..32 are all copies of the sign.
  assign w_ovf   = ~((&r_p[64:32]) | ~(|r_p[64:32]));

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (ctrl_MULT)     w_next = S_M_ITER;
    else if (ctrl_DIV) w_next = S_D_NEGA;
    else begin
      case (r_state)
        S_M_ITER: if (r_cnt == 5'd31) w_next = S_DONE;
        S_D_NEGA: w_next = S_D_NEGB;
        S_D_NEGB: w_next = S_D_ITER;
        S_D_ITER: if (r_cnt == 5'd31) w_next = S_D_NEGQ;
        S_D_NEGQ: w_next = S_DONE;
        S_DONE:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Adder operands come from registered state only, so the loop through the
  // external adder is a single combinational pass per cycle.
  always_comb begin
    w_add_x   = 32'd0;
    w_add_y   = 32'd0;
    w_add_cin = 1'b0;
    case (r_state)
      S_M_ITER: begin
        w_add_x = r_p[64:33];
        case (r_p[1:0])
          2'b01:   w_add_y = r_a;
          2'b10: begin
            w_add_y   = ~r_a;
            w_add_cin = 1'b1;
          end
          default: w_add_y = 32'd0;
        endcase
      end
      S_D_NEGA: begin
        w_add_x   = ~r_q;
        w_add_cin = 1'b1;
      end
      S_D_NEGB: begin
        w_add_x   = ~r_b;
        w_add_cin = 1'b1;
      end
      S_D_ITER: begin
        w_add_x   = w_rsh;
        w_add_y   = ~r_b;
        w_add_cin = 1'b1;
      end
      S_D_NEGQ: begin
        w_add_x   = ~r_q;
        w_add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_p      <= 65'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_q      <= 32'd0;
      r_r      <= 32'd0;
      r_cnt    <= 5'd0;
      r_sign   <= 1'b0;
      r_dz     <= 1'b0;
      r_mul    <= 1'b0;
      r_result <= 32'd0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_clr    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      r_clr <= 1'b0;
      if (r_clr) begin
        r_result <= 32'd0;
        r_exc    <= 1'b0;
      end
      // The finishing operation still reports even if a new start lands on this edge.
      if (r_state == S_DONE) begin
        r_rdy <= 1'b1;
        if (r_mul) begin
          r_result <= r_p[32:1];
          r_exc    <= w_ovf;
        end else begin
          r_result <= r_dz ? 32'd0 : r_q;
          r_exc    <= r_dz;
        end
      end
      if (w_start) begin
        r_a    <= data_operandA;
        r_b    <= data_operandB;
        r_q    <= data_operandA;
        r_r    <= 32'd0;
        r_p    <= {32'd0, data_operandB, 1'b0};
        r_sign <= data_operandA[31] ^ data_operandB[31];
        r_dz   <= (data_operandB == 32'd0);
        r_mul  <= ctrl_MULT;
        r_cnt  <= 5'd0;
        r_clr  <= 1'b1;
      end else begin
        case (r_state)
          S_M_ITER: begin
            r_p   <= {w_sum33[32], w_sum33[31:0], r_p[32:1]};
            r_cnt <= r_cnt + 5'd1;
          end
          S_D_NEGA: if (r_q[31]) r_q <= add_sum;
          S_D_NEGB: if (r_b[31]) r_b <= add_sum;
          S_D_ITER: begin
            if (add_cout) begin
              r_r <= add_sum;
              r_q <= {r_q[30:0], 1'b1};
            end else begin
              r_r <= w_rsh;
              r_q <= {r_q[30:0], 1'b0};
            end
            r_cnt <= r_cnt + 5'd1;
          end
          S_D_NEGQ: if (r_sign) r_q <= add_sum;
          default: ;
        endcase
      end
    end
  end

  assign add_x          = w_add_x;
  assign add_y          = w_add_y;
  assign add_cin        = w_add_cin;
  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = (r_state != S_IDLE);
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq with a behavioural model of the shared adder.
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;
  logic [31:0] add_x, add_y, add_sum;
  logic        add_cin, add_cout;
  logic [2:0]  o_dbg_state;

  int total = 0;
  int bad   = 0;

  multdiv_seq dut (
    .clock(clock), .reset_n(reset_n),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .o_dbg_state(o_dbg_state)
  );

  // Clock / external carry-select adder stand-in
  always #5 clock = ~clock;
  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};

  // Driver: start an op on edge E0, return edges counted until ready is seen.
  task automatic do_op(input logic is_mul, input logic [31:0] a, input logic [31:0] b,
                       output int edges, output logic [31:0] res, output logic exc,
                       output logic busy_e0, output logic [31:0] res_e1);
    int n;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = is_mul;
    ctrl_DIV      = ~is_mul;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    busy_e0   = busy;
    res_e1    = 32'hDEADBEEF;
    n = 0;
    while (n < 60) begin
      @(posedge clock); #1;
      n++;
      if (n == 1) res_e1 = data_result;
      if (data_resultRDY) break;
    end
    edges = n;
    res   = data_result;
    exc   = data_exception;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    data_operandA = 32'd0; data_operandB = 32'd0;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    total++; if (data_result !== 32'd0) begin bad++; $display("FAIL reset_result got %h want 0", data_result); end
    total++; if (data_exception !== 1'b0) begin bad++; $display("FAIL reset_exc got %b want 0", data_exception); end
    total++; if (data_resultRDY !== 1'b0) begin bad++; $display("FAIL reset_rdy got %b want 0", data_resultRDY); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_ops(input logic is_mul);
    logic [31:0] va [5], vb [5], vr [5];
    logic        ve [5];
    int          edges, want_edges;
    logic [31:0] res, res_e1;
    logic        exc, busy_e0;
    if (is_mul) begin
      va = '{32'd7, 32'h40000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
      vb = '{32'hFFFFFFFD, 32'd4, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vr = '{32'hFFFFFFEB, 32'h0, 32'h80000000, 32'h80000000, 32'd1};
      ve = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      want_edges = 33;
    end else begin
      va = '{32'hFFFFFF9C, 32'h80000000, 32'd5, 32'hFFFFFFF9, 32'd100};
      vb = '{32'd7, 32'h80000000, 32'd0, 32'hFFFFFFFE, 32'hFFFFFFF9};
      vr = '{32'hFFFFFFF2, 32'd1, 32'd0, 32'd3, 32'hFFFFFFF2};
      ve = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      want_edges = 36;
    end
    for (int i = 0; i < 5; i++) begin
      do_op(is_mul, va[i], vb[i], edges, res, exc, busy_e0, res_e1);
      total++; if (edges !== want_edges) begin bad++; $display("FAIL op%0d_%0d_latency got %0d want %0d", is_mul, i, edges, want_edges); end
      total++; if (res !== vr[i]) begin bad++; $display("FAIL op%0d_%0d_result got %h want %h", is_mul, i, res, vr[i]); end
      total++; if (exc !== ve[i]) begin bad++; $display("FAIL op%0d_%0d_exc got %b want %b", is_mul, i, exc, ve[i]); end
      total++; if (busy_e0 !== 1'b1) begin bad++; $display("FAIL op%0d_%0d_busy got %b want 1", is_mul, i, busy_e0); end
      total++; if (res_e1 !== 32'd0) begin bad++; $display("FAIL op%0d_%0d_clear got %h want 0", is_mul, i, res_e1); end
      @(posedge clock); #1;
      total++; if (data_resultRDY !== 1'b0 || data_result !== vr[i] || busy !== 1'b0) begin
        bad++; $display("FAIL op%0d_%0d_hold got rdy=%b res=%h busy=%b want rdy=0 res=%h busy=0",
                        is_mul, i, data_resultRDY, data_result, busy, vr[i]);
      end
    end
  endtask

  task automatic test_restart();
    int          edges, pulses;
    logic [31:0] res, res_e1;
    logic        exc, busy_e0;
    pulses = 0;
    @(negedge clock);
    data_operandA = 32'hFFFFFF9C; data_operandB = 32'd7; ctrl_DIV = 1'b1;
    @(posedge clock); #1; ctrl_DIV = 1'b0;
    repeat (9) begin @(posedge clock); #1; if (data_resultRDY) pulses++; end
    do_op(1'b1, 32'd6, 32'd9, edges, res, exc, busy_e0, res_e1);
    repeat (45) begin @(posedge clock); #1; if (data_resultRDY) pulses++; end
    total++; if (edges !== 33) begin bad++; $display("FAIL restart_latency got %0d want 33", edges); end
    total++; if (res !== 32'd54) begin bad++; $display("FAIL restart_result got %h want 00000036", res); end
    total++; if (pulses !== 0) begin bad++; $display("FAIL restart_extra_rdy got %0d want 0", pulses); end
  endtask

  task automatic test_midreset();
    int          edges, pulses;
    logic [31:0] res, res_e1;
    logic        exc, busy_e0;
    pulses = 0;
    @(negedge clock);
    data_operandA = 32'd7; data_operandB = 32'hFFFFFFFD; ctrl_MULT = 1'b1;
    @(posedge clock); #1; ctrl_MULT = 1'b0;
    repeat (14) @(posedge clock);
    @(negedge clock); reset_n = 1'b0;
    @(posedge clock); #1;
    total++; if (busy !== 1'b0 || data_resultRDY !== 1'b0 || data_result !== 32'd0) begin
      bad++; $display("FAIL midreset_outputs got busy=%b rdy=%b res=%h want 0 0 0", busy, data_resultRDY, data_result);
    end
    @(negedge clock); reset_n = 1'b1;
    repeat (40) begin @(posedge clock); #1; if (data_resultRDY) pulses++; end
    total++; if (pulses !== 0) begin bad++; $display("FAIL midreset_rdy got %0d want 0", pulses); end
    do_op(1'b1, 32'd2, 32'd3, edges, res, exc, busy_e0, res_e1);
    total++; if (res !== 32'd6 || exc !== 1'b0 || edges !== 33) begin
      bad++; $display("FAIL midreset_after got res=%h exc=%b edges=%0d want 6 0 33", res, exc, edges);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clock);
    data_operandA = 32'd3; data_operandB = 32'd5; ctrl_MULT = 1'b1;
    @(posedge clock); #1; ctrl_MULT = 1'b0;
    repeat (32) @(posedge clock);
    @(negedge clock);
    data_operandA = 32'd4; data_operandB = 32'd5; ctrl_MULT = 1'b1;
    @(posedge clock); #1; ctrl_MULT = 1'b0;
    total++; if (data_resultRDY !== 1'b1 || data_result !== 32'd15) begin
      bad++; $display("FAIL b2b_first got rdy=%b res=%h want 1 0000000f", data_resultRDY, data_result);
    end
    @(posedge clock); #1;
    total++; if (data_resultRDY !== 1'b0 || data_result !== 32'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL b2b_clear got rdy=%b res=%h busy=%b want 0 0 1", data_resultRDY, data_result, busy);
    end
    n = 1;
    while (n < 60 && !data_resultRDY) begin @(posedge clock); #1; n++; end
    total++; if (n !== 33 || data_result !== 32'd20) begin
      bad++; $display("FAIL b2b_second got edges=%0d res=%h want 33 00000014", n, data_result);
    end
  endtask

  initial begin
    test_reset();
    test_ops(1'b1);
    test_ops(1'b0);
    test_restart();
    test_midreset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
